// File: rtl/ddr_rd_arbiter.sv
// Round-robin arbiter sharing one DDR read port among NUM requesters; forwards
// the 16-bit return beats of the granted transfer and flags unexpected beats.
module ddr_rd_arbiter #(
  parameter int NUM            = 2,
  parameter int WIDTH_ddr_addr = 25,
  parameter int BEATS_PER_WORD = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM-1:0]                rq_start,
  input  logic [NUM*WIDTH_ddr_addr-1:0] rq_addr,
  input  logic [NUM*WIDTH_ddr_addr-1:0] rq_len,
  output logic [NUM-1:0]                rq_grant,
  output logic [15:0]                   rq_data,
  output logic [NUM-1:0]                rq_en,
  output logic [NUM-1:0]                rq_done,
  output logic                          ddr_req,
  output logic [WIDTH_ddr_addr-1:0]     ddr_addr,
  output logic [WIDTH_ddr_addr-1:0]     ddr_len,
  input  logic [15:0]                   ddr_data,
  input  logic                          ddr_en,
  output logic                          err_ovf
);

  localparam int AW = WIDTH_ddr_addr;
  localparam int CW = WIDTH_ddr_addr + 2;
  localparam int PW = (NUM > 1) ? $clog2(NUM) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, XFER, DONE} state_t;

  state_t         state_q, state_d;
  logic [NUM-1:0] pending_q, pending_d;
  logic [NUM-1:0] grant_q, grant_d;
  logic [NUM-1:0] en_q, en_d;
  logic [NUM-1:0] done_q, done_d;
  logic [PW-1:0]  ptr_q, ptr_d;
  logic [CW-1:0]  total_q, total_d;
  logic [CW-1:0]  count_q, count_d;
  logic           req_q, req_d;
  logic           ovf_q, ovf_d;
  logic [15:0]    data_q, data_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic [AW-1:0]  len_q, len_d;
  logic [AW-1:0]  slot_addr_q [NUM];
  logic [AW-1:0]  slot_addr_d [NUM];
  logic [AW-1:0]  slot_len_q  [NUM];
  logic [AW-1:0]  slot_len_d  [NUM];

  logic           win_found;
  logic [PW-1:0]  win_idx;
  logic [PW-1:0]  cand_idx;
  logic [NUM-1:0] win_onehot;

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand_idx  = '0;
    for (int k = 1; k <= NUM; k++) begin
      cand_idx = PW'((int'(ptr_q) + k) % NUM);
      if (!win_found && pending_q[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  assign win_onehot = NUM'(1) << win_idx;

  // NOTE: every always_comb output gets a default first, so no path can leave a latch.
  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    grant_d     = grant_q;
    en_d        = '0;
    done_d      = '0;
    ptr_d       = ptr_q;
    total_d     = total_q;
    count_d     = count_q;
    req_d       = req_q;
    ovf_d       = ovf_q;
    data_d      = data_q;
    addr_d      = addr_q;
    len_d       = len_q;
    slot_addr_d = slot_addr_q;
    slot_len_d  = slot_len_q;

    // Starts only land in empty slots; pending_q drives selection, so a start
    // seen this cycle cannot win this cycle.
    for (int i = 0; i < NUM; i++) begin
      if (rq_start[i] && !pending_q[i] && !grant_q[i]) begin
        pending_d[i]  = 1'b1;
        slot_addr_d[i] = rq_addr[i*AW +: AW];
        slot_len_d[i]  = rq_len[i*AW +: AW];
      end
    end

    unique case (state_q)
      IDLE: begin
        if (ddr_en) ovf_d = 1'b1;
        if (win_found) begin
          pending_d[win_idx] = 1'b0;
          grant_d = win_onehot;
          ptr_d   = win_idx;
          addr_d  = slot_addr_q[win_idx];
          len_d   = slot_len_q[win_idx];
          total_d = CW'(slot_len_q[win_idx]) * CW'(BEATS_PER_WORD);
          count_d = '0;
          if (slot_len_q[win_idx] == '0) begin
            state_d = DONE;
            done_d  = win_onehot;
          end else begin
            state_d = ISSUE;
            req_d   = 1'b1;
          end
        end
      end
      ISSUE, XFER: begin
        if (ddr_en) begin
          en_d    = grant_q;
          data_d  = ddr_data;
          count_d = count_q + 1'b1;
          req_d   = 1'b0;
          if (count_d == total_q) begin
            state_d = DONE;
            done_d  = grant_q;
          end else begin
            state_d = XFER;
          end
        end
      end
      DONE: begin
        if (ddr_en) ovf_d = 1'b1;
        grant_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state updates use <= so every flop samples pre-edge values regardless of order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      pending_q <= '0;
      grant_q   <= '0;
      en_q      <= '0;
      done_q    <= '0;
      ptr_q     <= PW'(NUM - 1);
      total_q   <= '0;
      count_q   <= '0;
      req_q     <= 1'b0;
      ovf_q     <= 1'b0;
      data_q    <= '0;
      addr_q    <= '0;
      len_q     <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      grant_q   <= grant_d;
      en_q      <= en_d;
      done_q    <= done_d;
      ptr_q     <= ptr_d;
      total_q   <= total_d;
      count_q   <= count_d;
      req_q     <= req_d;
      ovf_q     <= ovf_d;
      data_q    <= data_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
    end
  end

  // NOTE: request slots carry no reset; a slot is only read while its pending bit is set.
  always_ff @(posedge clk) begin
    slot_addr_q <= slot_addr_d;
    slot_len_q  <= slot_len_d;
  end

  assign rq_grant = grant_q;
  assign rq_data  = data_q;
  assign rq_en    = en_q;
  assign rq_done  = done_q;
  assign ddr_req  = req_q;
  assign ddr_addr = addr_q;
  assign ddr_len  = len_q;
  assign err_ovf  = ovf_q;

endmodule

// File: tb/tb_ddr_rd_arbiter.sv
// Self-checking bench for ddr_rd_arbiter: directed vector table, corner-case
// sequences and random traffic against a transaction-level reference model.
module tb_ddr_rd_arbiter;

  localparam int NUM = 2;
  localparam int AW  = 25;
  localparam int BPW = 4;

  logic              clk;
  logic              reset;
  logic [NUM-1:0]    rq_start;
  logic [NUM*AW-1:0] rq_addr;
  logic [NUM*AW-1:0] rq_len;
  logic [NUM-1:0]    rq_grant;
  logic [15:0]       rq_data;
  logic [NUM-1:0]    rq_en;
  logic [NUM-1:0]    rq_done;
  logic              ddr_req;
  logic [AW-1:0]     ddr_addr;
  logic [AW-1:0]     ddr_len;
  logic [15:0]       ddr_data;
  logic              ddr_en;
  logic              err_ovf;

  ddr_rd_arbiter #(.NUM(NUM), .WIDTH_ddr_addr(AW), .BEATS_PER_WORD(BPW)) dut (
    .clk(clk), .reset(reset),
    .rq_start(rq_start), .rq_addr(rq_addr), .rq_len(rq_len),
    .rq_grant(rq_grant), .rq_data(rq_data), .rq_en(rq_en), .rq_done(rq_done),
    .ddr_req(ddr_req), .ddr_addr(ddr_addr), .ddr_len(ddr_len),
    .ddr_data(ddr_data), .ddr_en(ddr_en), .err_ovf(err_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Reference model: pending requests, current owner, beats still owed.
  bit            m_pend [NUM];
  int            m_pend_cyc [NUM];
  logic [AW-1:0] m_addr [NUM];
  logic [AW-1:0] m_len [NUM];
  int            m_owner, m_last, m_left, m_prev_owner;
  bit            m_cool, m_first_seen, m_done_due, m_prev_beat, m_err;
  logic [15:0]   m_prev_data;
  logic [AW-1:0] m_ddr_addr, m_ddr_len;

  // Observations and stimulus requests.
  int            n_en [NUM];
  int            n_done [NUM];
  int            done_cyc [NUM];
  int            n_accepted;
  bit            req_seen;
  int            grant_log [$];
  logic [AW-1:0] addr_log [$];
  logic [NUM-1:0] st_mask;
  logic [AW-1:0] st_addr [NUM];
  logic [AW-1:0] st_len [NUM];
  bit            inj_beat, auto_beats;

  typedef struct {
    logic [1:0]    mask;
    logic [AW-1:0] addr0, len0, addr1, len1;
    int            en0, en1, done0, done1, first;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      if (n_errors <= 40)
        $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [NUM-1:0] onehot(input int i);
    if (i < 0) return '0;
    return NUM'(1) << i;
  endfunction

  function automatic int rr_pick(input int n);
    for (int k = 1; k <= NUM; k++) begin
      int i;
      i = (m_last + k) % NUM;
      if (m_pend[i] && m_pend_cyc[i] <= n - 2) return i;
    end
    return -1;
  endfunction

  function automatic bit model_idle();
    bit any;
    any = 1'b0;
    for (int i = 0; i < NUM; i++) any |= m_pend[i];
    return (m_owner < 0) && !m_cool && !any && !m_done_due;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NUM; i++) begin
      m_pend[i] = 1'b0;
      m_pend_cyc[i] = 0;
    end
    m_owner = -1; m_last = NUM - 1; m_left = 0; m_prev_owner = -1;
    m_cool = 1'b0; m_first_seen = 1'b0; m_done_due = 1'b0;
    m_prev_beat = 1'b0; m_err = 1'b0;
    m_ddr_addr = '0; m_ddr_len = '0;
  endtask

  task automatic clear_stats();
    for (int i = 0; i < NUM; i++) begin
      n_en[i] = 0; n_done[i] = 0; done_cyc[i] = -1;
    end
    n_accepted = 0; req_seen = 1'b0;
    grant_log.delete(); addr_log.delete();
  endtask

  task automatic start(input int i, input logic [AW-1:0] a, input logic [AW-1:0] l);
    st_mask[i] = 1'b1; st_addr[i] = a; st_len[i] = l;
  endtask

  // One clock: check outputs against the model at the falling edge, then drive.
  task automatic cycle();
    int          win;
    bit          beat, release_now;
    logic [15:0] data;
    @(negedge clk);
    cyc++;
    if (m_cool) begin
      check("grant_idle_gap", 64'(rq_grant), 64'd0);
      m_cool = 1'b0;
    end else if (m_owner < 0) begin
      win = rr_pick(cyc);
      check("grant_select", 64'(rq_grant), 64'(onehot(win)));
      if (win >= 0) begin
        m_owner = win; m_pend[win] = 1'b0; m_last = win;
        m_ddr_addr = m_addr[win]; m_ddr_len = m_len[win];
        m_left = int'(m_len[win]) * BPW;
        m_first_seen = 1'b0;
        m_done_due = (m_left == 0);
        grant_log.push_back(win); addr_log.push_back(m_addr[win]);
      end
    end else begin
      check("grant_hold", 64'(rq_grant), 64'(onehot(m_owner)));
    end

    check("rq_en", 64'(rq_en), m_prev_beat ? 64'(onehot(m_prev_owner)) : 64'd0);
    if (m_prev_beat) check("rq_data", 64'(rq_data), 64'(m_prev_data));
    check("rq_done", 64'(rq_done), m_done_due ? 64'(onehot(m_owner)) : 64'd0);
    check("ddr_req", 64'(ddr_req), 64'(m_owner >= 0 && m_ddr_len != 0 && !m_first_seen));
    check("ddr_addr", 64'(ddr_addr), 64'(m_ddr_addr));
    check("ddr_len", 64'(ddr_len), 64'(m_ddr_len));
    check("err_ovf", 64'(err_ovf), 64'(m_err));

    for (int i = 0; i < NUM; i++) begin
      n_en[i] += int'(rq_en[i]);
      if (rq_done[i]) begin
        n_done[i]++;
        done_cyc[i] = cyc;
      end
    end
    if (ddr_req) req_seen = 1'b1;
    release_now = m_done_due;
    m_done_due = 1'b0;

    m_prev_beat = 1'b0;
    beat = 1'b0;
    if (inj_beat) begin
      beat = 1'b1;
      inj_beat = 1'b0;
    end else if (auto_beats && m_owner >= 0 && m_left > 0 && $urandom_range(3) != 0) begin
      beat = 1'b1;
    end
    data = 16'($urandom);
    if (beat) begin
      if (m_owner >= 0 && m_left > 0) begin
        m_prev_beat = 1'b1; m_prev_data = data; m_prev_owner = m_owner;
        m_left--; m_first_seen = 1'b1;
        if (m_left == 0) m_done_due = 1'b1;
      end else begin
        m_err = 1'b1;
      end
    end
    ddr_en = beat;
    ddr_data = data;

    rq_start = '0;
    for (int i = 0; i < NUM; i++) begin
      rq_addr[i*AW +: AW] = AW'($urandom);
      rq_len[i*AW +: AW]  = AW'($urandom);
      if (st_mask[i]) begin
        rq_start[i] = 1'b1;
        rq_addr[i*AW +: AW] = st_addr[i];
        rq_len[i*AW +: AW]  = st_len[i];
        if (!m_pend[i] && m_owner != i) begin
          m_pend[i] = 1'b1; m_pend_cyc[i] = cyc;
          m_addr[i] = st_addr[i]; m_len[i] = st_len[i];
          n_accepted++;
        end
      end
    end
    st_mask = '0;

    if (release_now) begin
      m_owner = -1;
      m_cool = 1'b1;
    end
  endtask

  task automatic run_until_idle(input int budget);
    int k;
    k = 0;
    while (!model_idle() && k < budget) begin
      cycle();
      k++;
    end
    check("drain_within_budget", 64'(model_idle()), 64'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; rq_start = '0; ddr_en = 1'b0; st_mask = '0; inj_beat = 1'b0;
    @(negedge clk);
    check("rst_grant", 64'(rq_grant), 64'd0);
    check("rst_en", 64'(rq_en), 64'd0);
    check("rst_done", 64'(rq_done), 64'd0);
    check("rst_data", 64'(rq_data), 64'd0);
    check("rst_req", 64'(ddr_req), 64'd0);
    check("rst_addr", 64'(ddr_addr), 64'd0);
    check("rst_len", 64'(ddr_len), 64'd0);
    check("rst_err", 64'(err_ovf), 64'd0);
    reset = 1'b0;
    model_clear();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d of %0d checks", n_errors, n_checks);
    $fatal(1);
  end

  initial begin
    int s, k;
    reset = 1'b1; rq_start = '0; rq_addr = '0; rq_len = '0;
    ddr_en = 1'b0; ddr_data = '0; st_mask = '0; inj_beat = 1'b0; auto_beats = 1'b1;
    model_clear();
    clear_stats();

    //        mask   addr0        len0   addr1           len1   en0 en1 d0 d1 first
    vecs[0] = '{2'b01, 25'h100,   25'd3, 25'h0,          25'd0, 12, 0,  1, 0, 0};
    vecs[1] = '{2'b11, 25'h010,   25'd1, 25'h020,        25'd1, 4,  4,  1, 1, 0};
    vecs[2] = '{2'b10, 25'h0,     25'd0, 25'h040,        25'd0, 0,  0,  0, 1, 1};
    vecs[3] = '{2'b10, 25'h0,     25'd0, 25'h1FF_FFFF,   25'd2, 0,  8,  0, 1, 1};
    vecs[4] = '{2'b11, 25'h0AB,   25'd0, 25'h0CD,        25'd2, 0,  8,  1, 1, 0};
    vecs[5] = '{2'b01, 25'h123,   25'd5, 25'h0,          25'd0, 20, 0,  1, 0, 0};

    for (int v = 0; v < 6; v++) begin
      do_reset();
      clear_stats();
      if (vecs[v].mask[0]) start(0, vecs[v].addr0, vecs[v].len0);
      if (vecs[v].mask[1]) start(1, vecs[v].addr1, vecs[v].len1);
      cycle();
      run_until_idle(300);
      check("vec_en0", 64'(n_en[0]), 64'(vecs[v].en0));
      check("vec_en1", 64'(n_en[1]), 64'(vecs[v].en1));
      check("vec_done0", 64'(n_done[0]), 64'(vecs[v].done0));
      check("vec_done1", 64'(n_done[1]), 64'(vecs[v].done1));
      check("vec_first", 64'((grant_log.size() > 0) ? grant_log[0] : -1), 64'(vecs[v].first));
      check("vec_first_addr", 64'((addr_log.size() > 0) ? addr_log[0] : '1),
            64'((vecs[v].first == 0) ? vecs[v].addr0 : vecs[v].addr1));
    end

    // Contention ordering follows the round-robin pointer.
    do_reset();
    clear_stats();
    start(0, 25'h10, 25'd1); start(1, 25'h20, 25'd1);
    cycle();
    run_until_idle(200);
    start(0, 25'h30, 25'd1);
    cycle();
    run_until_idle(200);
    start(0, 25'h40, 25'd1); start(1, 25'h50, 25'd1);
    cycle();
    run_until_idle(200);
    check("rr_count", 64'(grant_log.size()), 64'd5);
    if (grant_log.size() == 5) begin
      check("rr_order0", 64'(grant_log[0]), 64'd0);
      check("rr_order1", 64'(grant_log[1]), 64'd1);
      check("rr_order3", 64'(grant_log[3]), 64'd1);
      check("rr_order4", 64'(grant_log[4]), 64'd0);
    end

    // Zero length: done within two cycles, no DDR request.
    do_reset();
    clear_stats();
    start(1, 25'h77, 25'd0);
    s = cyc + 1;
    cycle();
    run_until_idle(50);
    check("zero_done_count", 64'(n_done[1]), 64'd1);
    check("zero_done_latency_ok", 64'(done_cyc[1] >= 0 && done_cyc[1] - s <= 2), 64'd1);
    check("zero_no_req", 64'(req_seen), 64'd0);

    // Duplicate starts while pending and while granted are ignored.
    do_reset();
    clear_stats();
    start(0, 25'h100, 25'd2);
    cycle();
    start(0, 25'h200, 25'd2);
    cycle();
    k = 0;
    while (m_owner != 0 && k < 10) begin
      cycle();
      k++;
    end
    start(0, 25'h200, 25'd2);
    cycle();
    run_until_idle(200);
    check("dup_done_count", 64'(n_done[0]), 64'd1);
    check("dup_issue_count", 64'(addr_log.size()), 64'd1);
    check("dup_addr", 64'((addr_log.size() > 0) ? addr_log[0] : '1), 64'h100);
    check("dup_beats", 64'(n_en[0]), 64'd8);

    // Spurious beat in IDLE sets a sticky error and forwards nothing.
    do_reset();
    clear_stats();
    inj_beat = 1'b1;
    cycle();
    cycle();
    check("spur_err", 64'(err_ovf), 64'd1);
    start(0, 25'h300, 25'd1);
    cycle();
    run_until_idle(200);
    check("spur_err_sticky", 64'(err_ovf), 64'd1);
    check("spur_beats", 64'(n_en[0]), 64'd4);

    // Reset after beat 5 of a 12-beat transfer.
    do_reset();
    clear_stats();
    start(0, 25'h100, 25'd3);
    cycle();
    k = 0;
    while (n_en[0] < 5 && k < 100) begin
      cycle();
      k++;
    end
    check("mid_reached_beat5", 64'(n_en[0] >= 5), 64'd1);
    do_reset();
    for (int i = 0; i < 3; i++) cycle();
    check("mid_no_done", 64'(n_done[0]), 64'd0);
    inj_beat = 1'b1;
    cycle();
    cycle();
    check("mid_late_beat_err", 64'(err_ovf), 64'd1);
    do_reset();
    clear_stats();
    start(0, 25'h180, 25'd1);
    cycle();
    run_until_idle(200);
    check("mid_fresh_done", 64'(n_done[0]), 64'd1);
    check("mid_fresh_beats", 64'(n_en[0]), 64'd4);

    // Random traffic against the model.
    do_reset();
    clear_stats();
    for (int t = 0; t < 1500; t++) begin
      if ($urandom_range(5) == 0) begin
        for (int i = 0; i < NUM; i++)
          if ($urandom_range(1) == 1) start(i, AW'($urandom), AW'($urandom_range(3)));
      end
      cycle();
    end
    run_until_idle(500);
    check("rand_all_done", 64'(n_done[0] + n_done[1]), 64'(n_accepted));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
